// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } matmul_state_t;

    // Word addresses below this limit belong to the MMIO register block.
    localparam int unsigned MMIO_LIMIT       = 32'h1000;
    // MMIO word address of the MATMUL trigger flag, used by the integrating block.
    localparam int unsigned MMIO_MATMUL_FLAG = 32'hA00;

endpackage

// File: rtl/matmul_mac.sv
// Registered signed multiply-accumulate; the sum wraps modulo 2^ACC_WIDTH.
module matmul_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;

    assign w_prod   = $signed(i_a) * $signed(i_b);
    assign o_result = r_acc[DATA_WIDTH-1:0];

    // Accumulate sign-extended products; clear takes priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_WIDTH'(w_prod);
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one C = A x B job over a dual-port SRAM: port A reads A and
// writes C, port B reads B. Addresses come from incremental pointers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; config latched and checked on start
// ST_READ  | issue A[i][k] / B[k][j] reads, k = 0..N-1
// ST_DRAIN | last read data returns and is accumulated
// ST_WRITE | write truncated C[i][j], advance j/i, clear accumulator
// ST_FIN   | one-cycle done pulse, back to idle
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] c_base,
    input  logic [DATA_WIDTH-1:0] dim_m,
    input  logic [DATA_WIDTH-1:0] dim_n,
    input  logic [DATA_WIDTH-1:0] dim_p,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic                  mem_we_a,
    output logic [DATA_WIDTH-1:0] mem_wdata_a,
    output logic                  mem_we_b,
    input  logic [DATA_WIDTH-1:0] mem_q_a,
    input  logic [DATA_WIDTH-1:0] mem_q_b
);

    localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] MMIO_TOP = ADDR_WIDTH'(MMIO_LIMIT);

    matmul_state_t         r_state;
    logic                  r_busy, r_done, r_err, r_we, r_rd_v;
    logic [ADDR_WIDTH-1:0] r_addr_a, r_addr_b;
    logic [DATA_WIDTH-1:0] r_m, r_n, r_p;
    logic [DATA_WIDTH-1:0] r_i, r_j, r_k;
    logic [ADDR_WIDTH-1:0] r_b_base, r_a_row, r_b_col, r_c_ptr;

    logic                  w_zero_dim, w_mmio, w_mac_clear;
    logic                  w_last_k, w_last_j, w_last_i;
    logic [ADDR_WIDTH-1:0] w_next_a_row;
    logic [DATA_WIDTH-1:0] w_acc_lo;

    assign w_zero_dim   = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);
    assign w_mmio       = (a_base < MMIO_TOP) || (b_base < MMIO_TOP) || (c_base < MMIO_TOP);
    assign w_last_k     = (r_k == r_n - ONE_D);
    assign w_last_j     = (r_j == r_p - ONE_D);
    assign w_last_i     = (r_i == r_m - ONE_D);
    assign w_next_a_row = r_a_row + ADDR_WIDTH'(r_n);
    // Accumulator is zeroed when a job is accepted and after every C write.
    assign w_mac_clear  = (r_state == ST_WRITE) || ((r_state == ST_IDLE) && start);

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign mem_addr_a  = r_addr_a;
    assign mem_addr_b  = r_addr_b;
    assign mem_we_a    = r_we;
    assign mem_wdata_a = w_acc_lo;
    assign mem_we_b    = 1'b0;

    matmul_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_mac_clear),
        .i_en     (r_rd_v),
        .i_a      (mem_q_a),
        .i_b      (mem_q_b),
        .o_result (w_acc_lo)
    );

    // Job FSM with its counters, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_rd_v   <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_m      <= '0;
            r_n      <= '0;
            r_p      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_b_base <= '0;
            r_a_row  <= '0;
            r_b_col  <= '0;
            r_c_ptr  <= '0;
        end else begin
            r_done <= 1'b0;
            r_rd_v <= (r_state == ST_READ);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_m      <= dim_m;
                        r_n      <= dim_n;
                        r_p      <= dim_p;
                        r_b_base <= b_base;
                        r_a_row  <= a_base;
                        r_b_col  <= b_base;
                        r_c_ptr  <= c_base;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        if (w_zero_dim) begin
                            r_err   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else if (w_mmio) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_err    <= 1'b0;
                            r_busy   <= 1'b1;
                            r_addr_a <= a_base;
                            r_addr_b <= b_base;
                            r_state  <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_addr_a <= r_addr_a + ONE_A;
                    r_addr_b <= r_addr_b + ADDR_WIDTH'(r_p);
                    if (w_last_k) begin
                        r_k     <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_k <= r_k + ONE_D;
                    end
                end
                ST_DRAIN: begin
                    r_we     <= 1'b1;
                    r_addr_a <= r_c_ptr;
                    r_state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_we    <= 1'b0;
                    r_k     <= '0;
                    r_c_ptr <= r_c_ptr + ONE_A;
                    if (w_last_i && w_last_j) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else if (w_last_j) begin
                        r_j      <= '0;
                        r_i      <= r_i + ONE_D;
                        r_a_row  <= w_next_a_row;
                        r_b_col  <= r_b_base;
                        r_addr_a <= w_next_a_row;
                        r_addr_b <= r_b_base;
                        r_state  <= ST_READ;
                    end else begin
                        r_j      <= r_j + ONE_D;
                        r_b_col  <= r_b_col + ONE_A;
                        r_addr_a <= r_a_row;
                        r_addr_b <= r_b_col + ONE_A;
                        r_state  <= ST_READ;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a small synchronous SRAM model.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_base = '0, b_base = '0, c_base = '0;
    logic [31:0] dim_m = '0, dim_n = '0, dim_p = '0;
    logic        busy, done, err, mem_we_a, mem_we_b;
    logic [31:0] mem_addr_a, mem_addr_b, mem_wdata_a;
    logic [31:0] mem_q_a, mem_q_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a_base      (a_base),
        .b_base      (b_base),
        .c_base      (c_base),
        .dim_m       (dim_m),
        .dim_n       (dim_n),
        .dim_p       (dim_p),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_addr_a  (mem_addr_a),
        .mem_addr_b  (mem_addr_b),
        .mem_we_a    (mem_we_a),
        .mem_wdata_a (mem_wdata_a),
        .mem_we_b    (mem_we_b),
        .mem_q_a     (mem_q_a),
        .mem_q_b     (mem_q_b)
    );

    // SRAM model covering word addresses 0x1000..0x107F, one-cycle read latency.
    logic [31:0] mem [0:127];
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = '0, bd_data = '0;

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h1080);
    endfunction

    always @(posedge clk) begin
        mem_q_a <= in_rng(mem_addr_a) ? mem[mem_addr_a[6:0]] : 32'h0;
        mem_q_b <= in_rng(mem_addr_b) ? mem[mem_addr_b[6:0]] : 32'h0;
        if (mem_we_a && in_rng(mem_addr_a)) mem[mem_addr_a[6:0]] <= mem_wdata_a;
        if (bd_we) mem[bd_addr[6:0]] <= bd_data;
    end

    // Event monitor: counts busy cycles, done pulses and writes; records timing.
    int   cyc = 0, n_busy = 0, n_done = 0, n_we = 0, start_cyc = 0, done_cyc = 0;
    logic err_at_done = 1'b0;
    always @(posedge clk) begin
        if (start) start_cyc = cyc;
        if (busy) n_busy++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            err_at_done = err;
        end
        if (mem_we_a) n_we++;
        cyc++;
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[6:0]];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bd(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1;
        bd_addr = addr;
        bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] m, input logic [31:0] n, input logic [31:0] p);
        a_base = a; b_base = b; c_base = c;
        dim_m = m;  dim_n = n;  dim_p = p;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, done, 1'b1);
        @(negedge clk);
    endtask

    int s_we, s_busy, s_done;

    initial begin
        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_we_a", mem_we_a, 1'b0);
        check("rst_addr_a", mem_addr_a, 32'h0);

        bd(32'h1000, 32'd1); bd(32'h1001, 32'd2); bd(32'h1002, 32'd3); bd(32'h1003, 32'd4);
        bd(32'h1004, 32'd5); bd(32'h1005, 32'd6); bd(32'h1006, 32'd7); bd(32'h1007, 32'd8);
        bd(32'h1030, 32'hFFFFFFFF); bd(32'h1031, 32'd2); bd(32'h1032, 32'hFFFFFFFD);
        bd(32'h1034, 32'd4); bd(32'h1035, 32'd5); bd(32'h1036, 32'd6);
        for (int a = 32'h1020; a < 32'h1024; a++) bd(a, 32'hDEADBEEF);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 2x2x2 product
        cfg(32'h1000, 32'h1004, 32'h1010, 2, 2, 2);
        s_we = n_we; s_busy = n_busy; s_done = n_done;
        pulse_start();
        wait_done(100, "basic_done_seen");
        check("basic_c00", rd(32'h1010), 32'd19);
        check("basic_c01", rd(32'h1011), 32'd22);
        check("basic_c10", rd(32'h1012), 32'd43);
        check("basic_c11", rd(32'h1013), 32'd50);
        check("basic_writes", n_we - s_we, 4);
        check("basic_busy_cycles", n_busy - s_busy, 16);
        check("basic_done_latency", done_cyc - start_cyc, 17);
        check("basic_done_count", n_done - s_done, 1);
        check("basic_err", err_at_done, 1'b0);

        // Signed 1x3x1
        cfg(32'h1030, 32'h1034, 32'h1038, 1, 3, 1);
        s_busy = n_busy;
        pulse_start();
        wait_done(50, "signed_done_seen");
        check("signed_c", rd(32'h1038), 32'hFFFFFFF4);
        check("signed_busy_cycles", n_busy - s_busy, 5);
        check("signed_done_latency", done_cyc - start_cyc, 6);

        // Zero dimension
        cfg(32'h1000, 32'h1004, 32'h1040, 2, 0, 2);
        s_we = n_we; s_busy = n_busy;
        pulse_start();
        wait_done(10, "zero_done_seen");
        check("zero_done_latency", done_cyc - start_cyc, 1);
        check("zero_err", err_at_done, 1'b0);
        check("zero_writes", n_we - s_we, 0);
        check("zero_busy_cycles", n_busy - s_busy, 0);

        // MMIO base
        cfg(32'h1000, 32'h1004, 32'h0A00, 2, 2, 2);
        s_we = n_we; s_busy = n_busy;
        pulse_start();
        wait_done(10, "mmio_done_seen");
        check("mmio_done_latency", done_cyc - start_cyc, 1);
        check("mmio_err_at_done", err_at_done, 1'b1);
        check("mmio_writes", n_we - s_we, 0);
        check("mmio_busy_cycles", n_busy - s_busy, 0);
        repeat (3) @(negedge clk);
        check("mmio_err_sticky", err, 1'b1);
        cfg(32'h1000, 32'h1004, 32'h1018, 2, 2, 2);
        pulse_start();
        check("mmio_err_cleared", err, 1'b0);
        wait_done(100, "mmio_next_done_seen");
        check("mmio_next_err", err_at_done, 1'b0);
        check("mmio_next_c11", rd(32'h101B), 32'd50);

        // start while busy is ignored
        cfg(32'h1000, 32'h1004, 32'h1048, 2, 2, 2);
        s_we = n_we; s_busy = n_busy; s_done = n_done;
        pulse_start();
        repeat (4) @(negedge clk);
        cfg(32'h1000, 32'h1004, 32'h1060, 1, 1, 1);
        pulse_start();
        repeat (40) @(negedge clk);
        check("ign_done_count", n_done - s_done, 1);
        check("ign_writes", n_we - s_we, 4);
        check("ign_busy_cycles", n_busy - s_busy, 16);
        check("ign_c00", rd(32'h1048), 32'd19);
        check("ign_c10", rd(32'h104A), 32'd43);

        // Reset mid-job
        cfg(32'h1000, 32'h1004, 32'h1020, 2, 2, 2);
        s_done = n_done;
        pulse_start();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_we_a", mem_we_a, 1'b0);
        check("abort_addr_a", mem_addr_a, 32'h0);
        check("abort_addr_b", mem_addr_b, 32'h0);
        check("abort_wdata", mem_wdata_a, 32'h0);
        repeat (20) @(negedge clk);
        check("abort_c10_unwritten", rd(32'h1022), 32'hDEADBEEF);
        check("abort_c11_unwritten", rd(32'h1023), 32'hDEADBEEF);
        check("abort_no_done", n_done - s_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_done(100, "rerun_done_seen");
        check("rerun_c00", rd(32'h1020), 32'd19);
        check("rerun_c01", rd(32'h1021), 32'd22);
        check("rerun_c10", rd(32'h1022), 32'd43);
        check("rerun_c11", rd(32'h1023), 32'd50);
        check("rerun_err", err_at_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
